// File: rtl/lsu_ram_port.sv
// Load/store initiator between the memory stage and a byte-addressed data RAM.
// One request in flight: IDLE accepts, ACCESS strobes the RAM for one cycle, RESP holds the result.
module lsu_ram_port #(
  parameter int unsigned W         = 32,
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned TYPE_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [W-1:0]      req_addr,
  input  logic [W-1:0]      req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_rdata,
  output logic              rsp_err,
  output logic [W-1:0]      ram_addr,
  output logic [W-1:0]      ram_wdat,
  output logic              ram_we,
  output logic              ram_re,
  output logic [TYPE_W-1:0] ram_type,
  output logic              sign,
  input  logic [W-1:0]      ram_rdata
);

  localparam int unsigned AW1 = ADDR_BITS + 1;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e              state_q, state_d;
  logic [W-1:0]        ram_addr_q, ram_addr_d;
  logic [W-1:0]        ram_wdat_q, ram_wdat_d;
  logic                ram_we_q, ram_we_d;
  logic                ram_re_q, ram_re_d;
  logic [TYPE_W-1:0]   ram_type_q, ram_type_d;
  logic                sign_q, sign_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [W-1:0]        rsp_rdata_q, rsp_rdata_d;

  logic [2:0]          size_m1;
  logic [AW1-1:0]      last_byte;
  logic                f3_ok, hi_ok, legal;
  logic [TYPE_W-1:0]   req_type;

  // Request decode: legality and RAM size/mask code.
  always_comb begin
    size_m1 = 3'd3;
    req_type = TYPE_W'(4'b0000);
    f3_ok = 1'b0;
    unique case (req_funct3[1:0])
      2'b00:   size_m1 = 3'd0;
      2'b01:   size_m1 = 3'd1;
      default: size_m1 = 3'd3;
    endcase
    unique case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = ~req_we;
      default:                f3_ok = 1'b0;
    endcase
    // Widened sum catches accesses that would wrap past the top of the RAM.
    last_byte = {1'b0, req_addr[ADDR_BITS-1:0]} + AW1'(size_m1);
    hi_ok     = (req_addr[W-1:ADDR_BITS] == '0);
    legal     = f3_ok & hi_ok & ~last_byte[ADDR_BITS];
    if (req_we) begin
      unique case (req_funct3[1:0])
        2'b00:   req_type = TYPE_W'(4'b0001);
        2'b01:   req_type = TYPE_W'(4'b0011);
        default: req_type = TYPE_W'(4'b1111);
      endcase
    end else begin
      unique case (req_funct3[1:0])
        2'b00:   req_type = TYPE_W'(4'b0001);
        2'b01:   req_type = TYPE_W'(4'b0010);
        default: req_type = TYPE_W'(4'b1000);
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    ram_addr_d  = ram_addr_q;
    ram_wdat_d  = ram_wdat_q;
    ram_we_d    = 1'b0;
    ram_re_d    = 1'b0;
    ram_type_d  = '0;
    sign_d      = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (legal) begin
            state_d    = StAccess;
            ram_addr_d = req_addr;
            ram_wdat_d = req_wdata;
            ram_we_d   = req_we;
            ram_re_d   = ~req_we;
            ram_type_d = req_type;
            sign_d     = ~req_we & ~req_funct3[2];
          end else begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      StAccess: begin
        state_d     = StResp;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = ram_we_q ? '0 : ram_rdata;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ram_addr_q  <= '0;
      ram_wdat_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      ram_type_q  <= '0;
      sign_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdat_q  <= ram_wdat_d;
      ram_we_q    <= ram_we_d;
      ram_re_q    <= ram_re_d;
      ram_type_q  <= ram_type_d;
      sign_q      <= sign_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Ready is held low while reset is asserted.
  assign req_ready = (state_q == StIdle) & rst_n;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdat  = ram_wdat_q;
  assign ram_we    = ram_we_q;
  assign ram_re    = ram_re_q;
  assign ram_type  = ram_type_q;
  assign sign      = sign_q;

endmodule

// File: tb/tb_lsu_ram_port.sv
// Directed bench for lsu_ram_port with a small byte-addressed RAM model.
module tb_lsu_ram_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdat;
  logic        ram_we;
  logic        ram_re;
  logic [3:0]  ram_type;
  logic        sign;
  logic [31:0] ram_rdata;

  int n_tests = 0;
  int n_fail = 0;
  int we_cycles = 0;
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] ra;

  lsu_ram_port dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .ram_addr   (ram_addr),
    .ram_wdat   (ram_wdat),
    .ram_we     (ram_we),
    .ram_re     (ram_re),
    .ram_type   (ram_type),
    .sign       (sign),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: combinational read with extension, masked little-endian write.
  always_comb begin
    ram_rdata = '0;
    ra = ram_addr[7:0];
    case (ram_type)
      4'b0001: ram_rdata = {{24{sign & mem[ra][7]}}, mem[ra]};
      4'b0010: ram_rdata = {{16{sign & mem[ra+8'd1][7]}}, mem[ra+8'd1], mem[ra]};
      4'b1000: ram_rdata = {mem[ra+8'd3], mem[ra+8'd2], mem[ra+8'd1], mem[ra]};
      default: ram_rdata = '0;
    endcase
  end

  always @(posedge clk) begin
    if (ram_we) begin
      we_cycles <= we_cycles + 1;
      for (int i = 0; i < 4; i++)
        if (ram_type[i]) mem[8'(ram_addr[7:0] + 8'(i))] <= ram_wdat[8*i +: 8];
    end
  end

  task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %0h want 0", req_ready); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got %0h want 0", rsp_valid); end
    n_tests++; if ({ram_we, ram_re, ram_type, sign} !== 7'd0) begin n_fail++; $display("FAIL rst_strobes got %0h want 0", {ram_we, ram_re, ram_type, sign}); end
    n_tests++; if ({rsp_rdata, rsp_err, ram_addr} !== 65'd0) begin n_fail++; $display("FAIL rst_data got %0h want 0", {rsp_rdata, rsp_err, ram_addr}); end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got %0h want 1", req_ready); end
  endtask

  task automatic test_sw();
    drive_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    n_tests++; if (ram_we !== 1'b1 || ram_re !== 1'b0) begin n_fail++; $display("FAIL sw_we_re got %0h%0h want 10", ram_we, ram_re); end
    n_tests++; if (ram_type !== 4'b1111) begin n_fail++; $display("FAIL sw_type got %b want 1111", ram_type); end
    n_tests++; if (ram_addr !== 32'h10 || ram_wdat !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_addr_wdat got %h %h want 00000010 deadbeef", ram_addr, ram_wdat); end
    n_tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL sw_access_hs got %0h%0h want 00", rsp_valid, req_ready); end
    @(posedge clk); @(negedge clk);
    n_tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL sw_rsp got v%0h e%0h d%h want v1 e0 d00000000", rsp_valid, rsp_err, rsp_rdata); end
    n_tests++; if (ram_we !== 1'b0 || ram_type !== 4'b0000) begin n_fail++; $display("FAIL sw_resp_strobe got %0h %b want 0 0000", ram_we, ram_type); end
    n_tests++; if (ram_addr !== 32'h10) begin n_fail++; $display("FAIL sw_addr_hold got %h want 00000010", ram_addr); end
    handshake();
    n_tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL sw_done got v%0h r%0h want v0 r1", rsp_valid, req_ready); end
    n_tests++; if ({mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_mem got %h want deadbeef", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}); end
  endtask

  task automatic test_lb();
    drive_req(1'b0, 3'b000, 32'h13, 32'h0);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    n_tests++; if (ram_re !== 1'b1 || ram_we !== 1'b0) begin n_fail++; $display("FAIL lb_re_we got %0h%0h want 10", ram_re, ram_we); end
    n_tests++; if (ram_type !== 4'b0001 || sign !== 1'b1) begin n_fail++; $display("FAIL lb_type_sign got %b %0h want 0001 1", ram_type, sign); end
    @(posedge clk); @(negedge clk);
    n_tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFFFFFFDE || rsp_err !== 1'b0) begin n_fail++; $display("FAIL lb_rsp got v%0h d%h e%0h want v1 dffffffde e0", rsp_valid, rsp_rdata, rsp_err); end
    n_tests++; if (ram_re !== 1'b0 || sign !== 1'b0) begin n_fail++; $display("FAIL lb_idle_strobe got %0h%0h want 00", ram_re, sign); end
    handshake();
  endtask

  task automatic test_lhu_stall();
    drive_req(1'b0, 3'b101, 32'h10, 32'h0);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    n_tests++; if (ram_type !== 4'b0010 || sign !== 1'b0 || ram_re !== 1'b1) begin n_fail++; $display("FAIL lhu_access got t%b s%0h r%0h want t0010 s0 r1", ram_type, sign, ram_re); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      n_tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000BEEF) begin n_fail++; $display("FAIL lhu_hold%0d got v%0h d%h want v1 d0000beef", c, rsp_valid, rsp_rdata); end
      n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL lhu_ready%0d got %0h want 0", c, req_ready); end
    end
    handshake();
    n_tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL lhu_done got r%0h v%0h want r1 v0", req_ready, rsp_valid); end
  endtask

  task automatic test_illegal();
    logic [31:0] addrs [3] = '{32'h100, 32'hFE, 32'h0};
    logic [2:0]  f3s   [3] = '{3'b010, 3'b010, 3'b011};
    logic        wes   [3] = '{1'b0, 1'b1, 1'b0};
    int w0;
    for (int k = 0; k < 3; k++) begin
      w0 = we_cycles;
      drive_req(wes[k], f3s[k], addrs[k], 32'hCAFEF00D);
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      n_tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL ill%0d_rsp got v%0h e%0h d%h want v1 e1 d0", k, rsp_valid, rsp_err, rsp_rdata); end
      n_tests++; if (ram_we !== 1'b0 || ram_re !== 1'b0 || ram_type !== 4'b0000) begin n_fail++; $display("FAIL ill%0d_strobe got w%0h r%0h t%b want w0 r0 t0000", k, ram_we, ram_re, ram_type); end
      handshake();
      n_tests++; if (we_cycles != w0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL ill%0d_after got writes %0d err %0h want 0 0", k, we_cycles - w0, rsp_err); end
    end
  endtask

  task automatic test_back_to_back();
    int w0 = we_cycles;
    drive_req(1'b1, 3'b001, 32'h20, 32'h00001234);
    @(posedge clk); @(negedge clk);
    n_tests++; if (ram_type !== 4'b0011 || ram_we !== 1'b1) begin n_fail++; $display("FAIL sh_access got t%b w%0h want t0011 w1", ram_type, ram_we); end
    drive_req(1'b0, 3'b010, 32'h20, 32'h0);
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_access got %0h want 0", req_ready); end
    @(posedge clk); @(negedge clk);
    n_tests++; if (ram_we !== 1'b0 || req_ready !== 1'b0 || ram_re !== 1'b0) begin n_fail++; $display("FAIL b2b_resp got w%0h r%0h re%0h want 000", ram_we, req_ready, ram_re); end
    handshake();
    n_tests++; if (we_cycles - w0 != 1) begin n_fail++; $display("FAIL sh_we_cycles got %0d want 1", we_cycles - w0); end
    n_tests++; if (req_ready !== 1'b1 || ram_re !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got r%0h re%0h v%0h want 1 0 0", req_ready, ram_re, rsp_valid); end
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    n_tests++; if (ram_re !== 1'b1 || ram_type !== 4'b1000) begin n_fail++; $display("FAIL b2b_lw_access got re%0h t%b want 1 1000", ram_re, ram_type); end
    @(posedge clk); @(negedge clk);
    n_tests++; if (rsp_rdata !== 32'h00001234 || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_lw_rsp got %h v%0h want 00001234 v1", rsp_rdata, rsp_valid); end
    handshake();
  endtask

  task automatic test_reset_mid_store();
    drive_req(1'b1, 3'b000, 32'h40, 32'h000000AA);
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    n_tests++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_we got %0h want 1", ram_we); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_we_drop got %0h want 0", ram_we); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    n_tests++; if (mem[8'h40] !== 8'h00) begin n_fail++; $display("FAIL rstmid_mem got %h want 00", mem[8'h40]); end
    n_tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || ram_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_state got r%0h v%0h w%0h want 1 0 0", req_ready, rsp_valid, ram_we); end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_lb();
    test_lhu_stall();
    test_illegal();
    test_back_to_back();
    test_reset_mid_store();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ram_port.md
Name: lsu_ram_port

Overview:
- Load/store initiator between the core's memory stage and the byte-addressed data RAM.
- Accepts one load or store per handshake and decodes RV32 funct3 into the RAM's size/byte-enable code and sign flag.
- Drives the RAM for exactly one cycle, captures load data, and returns a held response with an error flag.
- One request outstanding at a time.

Parameters:
- W, 32, data and address width.
- ADDR_BITS, 8, RAM address width; the RAM holds 2**ADDR_BITS bytes.
- TYPE_W, 4, width of the RAM size/enable code.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 load/store funct3.
- req_addr  in  W  byte address.
- req_wdata  in  W  store data, LSB-aligned.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  W  load result, already sign- or zero-extended by the RAM.
- rsp_err  out  1  access fault or illegal funct3.
- ram_addr  out  W  RAM byte address.
- ram_wdat  out  W  RAM write data.
- ram_we  out  1  RAM write strobe.
- ram_re  out  1  RAM read strobe.
- ram_type  out  TYPE_W  RAM size code (load) or byte-enable mask (store).
- sign  out  1  RAM sign-extend select for loads.
- ram_rdata  in  W  RAM combinational read data (data_reg).

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - All outputs 0, except req_ready = 1 once rst_n deasserts.
  - Internal request registers cleared.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready: latch we, funct3, addr, wdata.
  - If the request is legal, go to ACCESS. Otherwise go to RESP with rsp_err = 1.
- Legality rules:
  - Loads: funct3 must be one of 000, 001, 010, 100, 101.
  - Stores: funct3 must be one of 000, 001, 010.
  - req_addr[W-1:ADDR_BITS] must be 0.
  - The last byte touched (addr + size - 1) must be < 2**ADDR_BITS. This check prevents in-RAM address wrap.
  - An illegal request never asserts ram_we or ram_re.
- ACCESS (exactly one cycle):
  - ram_addr = latched addr.
  - ram_wdat = latched wdata.
  - Stores: ram_we = 1, ram_re = 0, ram_type mask = 0001 (SB) / 0011 (SH) / 1111 (SW).
  - Loads: ram_re = 1, ram_we = 0, ram_type size code = 0001 (byte) / 0010 (half) / 1000 (word).
  - Loads: sign = ~funct3[2]. Stores: sign = 0.
  - At the closing clock edge: rsp_rdata <= ram_rdata for loads, rsp_rdata <= 0 for stores.
  - Next state: RESP.
- Outside ACCESS: ram_we = 0, ram_re = 0, ram_type = 0000, sign = 0. ram_addr and ram_wdat hold their last value.
- RESP:
  - rsp_valid = 1; req_ready = 0.
  - rsp_rdata and rsp_err stay stable until rsp_valid && rsp_ready.
  - On handshake: return to IDLE, clear rsp_valid and rsp_err.
  - No RESP-to-ACCESS bypass.
- Latency: request accepted at edge E0, RAM access during the cycle after E0, rsp_valid visible after E1. Best-case throughput is 1 request per 3 cycles.
- Response field rules:
  - rsp_rdata = 0 whenever rsp_err = 1.
  - rsp_err is valid only while rsp_valid = 1.
- Reset mid-operation: if rst_n asserts during ACCESS, ram_we drops immediately (async). No write occurs if the assertion precedes the edge. The pending response is discarded.
- All output strobes are registered; there are no combinational paths from req_* to ram_*.

Test Plan:
- SW, addr 0x10, wdata 0xDEADBEEF -> one ACCESS cycle with ram_we=1, ram_type=1111, ram_addr=0x10; then rsp_valid=1, rsp_err=0, rsp_rdata=0.
- LB, addr 0x13, RAM model returns 0xFFFFFFDE -> ram_re=1, ram_type=0001, sign=1; rsp_rdata=0xFFFFFFDE two cycles after acceptance.
- LHU, addr 0x10, rsp_ready held low 3 cycles -> ram_type=0010, sign=0; rsp_valid and rsp_rdata=0x0000BEEF stay stable all 3 cycles; req_ready=0 until the handshake.
- LW, addr 0x100; SW, addr 0xFE; load with funct3=011 -> rsp_err=1 each time; ram_we and ram_re never assert; response comes one cycle after acceptance.
- SH, addr 0x20, wdata 0x1234 -> ram_type=0011, ram_we for exactly one cycle; a back-to-back request held valid is accepted only after the RESP handshake.
- rst_n=0 asynchronously mid-cycle during a store's ACCESS -> ram_we falls immediately; after release the RAM byte is unchanged, the FSM is in IDLE, and rsp_valid=0.
